pattern_tx: RTL and testbench
=============================

Name: pattern_tx

Overview:
- Serial pattern transmitter. Emits a captured PAT_W-bit code on a one-bit line, MSB first, one bit per clock.
- Repeats the code a programmable number of times, with programmable idle gaps between repetitions.
- Serves as the sending side for the team's serial pattern detectors, e.g. a "001" lock. It drives the detector's serial input directly.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- PAT_W, 3, pattern length in bits (>=2)
- REP_W, 4, width of repetition-count input
- GAP_W, 4, width of inter-repetition gap input
- IDLE_BIT, 1'b1, level driven on `a` when not transmitting (1 keeps a 001-detector in its reset state)

Ports:
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- pattern  in  PAT_W  code to send; captured on accepted start
- reps  in  REP_W  number of transmissions; 0 treated as 1
- gap  in  GAP_W  idle cycles between transmissions; 0 = back-to-back
- abort  in  1  terminate current transmission
- a  out  1  serial data
- a_valid  out  1  high while `a` carries a pattern bit
- busy  out  1  high in SEND, GAP and DONE
- done  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low.
- Reset values, applied immediately on reset_n low: state IDLE, a=IDLE_BIT, a_valid=0, busy=0, done=0, all counters 0.
- Reset mid-transmission aborts with no done pulse.
- All outputs are registered; no combinational input-to-output path.

State machine (statetype: IDLE, SEND, GAP, DONE):
- IDLE
  - start=1 and abort=0 at edge t0: capture pattern, reps (0→1) and gap into shadow registers; go to SEND.
  - At the same edge t0, load a<=pattern[PAT_W-1] and a_valid<=1. The first bit is therefore visible in the cycle after t0 (latency 1).
- SEND
  - Bits shift out MSB→LSB, one per cycle; bit_cnt counts 0..PAT_W-1.
  - After the LSB cycle:
    - If repetitions remain and gap>0: go to GAP.
    - If repetitions remain and gap=0: stay in SEND, reload bit_cnt, and send the next MSB in the very next cycle.
    - If no repetitions remain: go to DONE.
- GAP
  - a=IDLE_BIT, a_valid=0, for exactly `gap` cycles; then back to SEND with the MSB.
- DONE
  - One cycle: done=1, a=IDLE_BIT, a_valid=0, busy=1.
  - Then IDLE. start is ignored in DONE.

Timing and counters:
- Total pattern-bit plus gap cycles = reps*PAT_W + (reps-1)*gap.
- done is high in the cycle immediately after the last LSB cycle.
- rep_cnt decrements once per completed transmission.
- All counters are unsigned. Each wraps only by explicit reload, never by overflow: rep_cnt and gap_cnt are sized to their inputs, and bit_cnt is $clog2(PAT_W) bits wide.

Boundary conditions:
- start while busy: ignored, with no effect on the captured values.
- Input changes after acceptance: no effect, because shadow registers are used.
- abort in SEND/GAP/DONE: at the next edge go to IDLE with a=IDLE_BIT, a_valid=0, busy=0, and no done pulse.
- abort together with start in IDLE: abort wins; start is dropped.
- abort in IDLE: no effect.
- start held high continuously: a new transmission is accepted in the first IDLE cycle after DONE. Minimum start-to-start spacing is therefore the transmission length + 2 cycles.
- Default case in every case statement: next state IDLE.

Decomposition:
- Shared package pattern_pkg holds:
  - typedef enum statetype {IDLE, SEND, GAP, DONE}
  - localparam DEFAULT_PATTERN = 3'b001
  - localparam IDLE_LEVEL = 1'b1
- The package is reused by the detector family.
- The datapath (shadow shift register plus bit counter) is a natural sub-module, pattern_shifter. It has load/shift controls and a last-bit flag; the FSM and rep/gap counters remain in pattern_tx.

Test Plan:
1. Reset, then start with pattern=3'b001, reps=1, gap=0.
   - a=0,0,1 with a_valid=1 on cycles t0+1..t0+3.
   - done=1 on t0+4; busy falls on t0+5.
   - A bench 001 Mealy detector model sees unlock=1 on t0+3.
2. pattern=3'b101, reps=3, gap=2.
   - a = 1,0,1,I,I,1,0,1,I,I,1,0,1 (I=IDLE_BIT, a_valid=0); 13 cycles.
   - done on cycle 14 after start.
3. reps=0, pattern=3'b011, gap=5: exactly one transmission (0,1,1), no gap cycles, done on t0+4.
4. Abort on second bit of a reps=2 transmission: next cycle a=1, a_valid=0, busy=0; done never pulses.
   - A following start is accepted normally.
5. Second start pulse and changed pattern during SEND: ignored; output stream matches the first pattern.
   - Also: start+abort together in IDLE → no transmission.
6. reset_n asserted asynchronously mid-GAP (between clock edges):
   - Outputs go to reset values immediately (a=1, busy=0, done=0).
   - After release, the first start behaves as in scenario 1.

Source files
------------

// File: rtl/pattern_pkg.sv
// pattern_pkg: shared state type and constants for the serial pattern transmitter/detector family.
package pattern_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} statetype;
    localparam logic [2:0] DEFAULT_PATTERN = 3'b001;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/pattern_tx_if.sv
// pattern_tx_if: control handshake and serial output bundle of pattern_tx.
interface pattern_tx_if
    import pattern_pkg::*;
#(
    parameter int PAT_W = $bits(DEFAULT_PATTERN),
    parameter int REP_W = 4,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [REP_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             a;
    logic             a_valid;
    logic             busy;
    logic             done;
    modport master (output start, abort, pattern, reps, gap, input a, a_valid, busy, done);
    modport slave  (input start, abort, pattern, reps, gap, output a, a_valid, busy, done);
endinterface

// File: rtl/pattern_shifter.sv
// pattern_shifter: shadow copy of the captured code plus the MSB-first shift register and bit counter.
module pattern_shifter #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             reload_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic             next_bit_o,
    output logic             msb_o,
    output logic             last_o
);
    localparam int CW = $clog2(PAT_W);
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-2:0] sr_q;
    logic [CW-1:0]    cnt_q;
    // sr_q holds the bits still to come after the one currently on the line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= '0;
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            pat_q <= pattern_i;
            sr_q  <= pattern_i[PAT_W-2:0];
            cnt_q <= '0;
        end else if (reload_i) begin
            sr_q  <= pat_q[PAT_W-2:0];
            cnt_q <= '0;
        end else if (shift_i) begin
            sr_q  <= sr_q << 1;
            cnt_q <= cnt_q + 1'b1;
        end
    end
    assign next_bit_o = sr_q[PAT_W-2];
    assign msb_o      = pat_q[PAT_W-1];
    assign last_o     = (cnt_q == CW'(PAT_W-1));
endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: repeats a captured code MSB-first on a serial line with programmable gaps and a start/busy/done handshake.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int   PAT_W    = 3,
    parameter int   REP_W    = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_BIT = IDLE_LEVEL
) (
    input logic         clk,
    input logic         reset_n,
    pattern_tx_if.slave bus
);
    statetype         state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
    logic             a_q, a_d, av_q, av_d, busy_q, busy_d, done_q, done_d;
    logic             load, reload, shift, next_bit, msb, last;

    pattern_shifter #(.PAT_W(PAT_W)) u_shifter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (load),
        .reload_i   (reload),
        .shift_i    (shift),
        .pattern_i  (bus.pattern),
        .next_bit_o (next_bit),
        .msb_o      (msb),
        .last_o     (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            a_q     <= IDLE_BIT;
            av_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            a_q     <= a_d;
            av_q    <= av_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        a_d     = IDLE_BIT;
        av_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        reload  = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: if (bus.start && !bus.abort) begin
                state_d = SEND;
                load    = 1'b1;
                rep_d   = (bus.reps == '0) ? REP_W'(1) : bus.reps;
                gap_d   = bus.gap;
                a_d     = bus.pattern[PAT_W-1];
                av_d    = 1'b1;
                busy_d  = 1'b1;
            end
            SEND: if (!last) begin
                shift = 1'b1;
                a_d   = next_bit;
                av_d  = 1'b1;
            end else begin
                rep_d = rep_q - 1'b1;
                if (rep_q == REP_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (gap_q == '0) begin
                    reload = 1'b1;
                    a_d    = msb;
                    av_d   = 1'b1;
                end else begin
                    state_d = GAP;
                    gcnt_d  = gap_q;
                end
            end
            GAP: if (gcnt_q == GAP_W'(1)) begin
                state_d = SEND;
                gcnt_d  = '0;
                reload  = 1'b1;
                a_d     = msb;
                av_d    = 1'b1;
            end else begin
                gcnt_d = gcnt_q - 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // abort overrides everything outside IDLE; in IDLE it only blocks acceptance
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            a_d     = IDLE_BIT;
            av_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            load    = 1'b0;
            reload  = 1'b0;
            shift   = 1'b0;
        end
    end

    assign bus.a       = a_q;
    assign bus.a_valid = av_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed plus randomized checks of pattern_tx against a cycle-list model of the serial stream.
module tb_pattern_tx;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [1:0] exp_q[$];
    int det_q = 0;
    logic unlock;

    pattern_tx_if #(.PAT_W(3), .REP_W(4), .GAP_W(4)) bus ();
    pattern_tx #(.PAT_W(3), .REP_W(4), .GAP_W(4), .IDLE_BIT(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // 001 Mealy lock fed from the serial line: counts consecutive zeros, unlocks on a following one
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) det_q <= 0;
        else det_q <= bus.a ? 0 : ((det_q == 2) ? 2 : det_q + 1);
    end
    assign unlock = (det_q == 2) && bus.a;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_a"}, bus.a, 1'b1);
        chk({tag, "_av"}, bus.a_valid, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_done"}, bus.done, 1'b0);
    endtask

    // expected line contents per cycle: {a, a_valid}
    task automatic build(input logic [2:0] p, input int r, input int g);
        int n;
        n = (r == 0) ? 1 : r;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            for (int b = 2; b >= 0; b--) exp_q.push_back({p[b], 1'b1});
            if (k < n - 1) repeat (g) exp_q.push_back(2'b10);
        end
    endtask

    task automatic run_tx(input logic [2:0] p, input int r, input int g, input bit rnd, input bit det);
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.pattern = p;
        bus.reps = 4'(r);
        bus.gap = 4'(g);
        step();
        bus.start = 1'b0;
        build(p, r, g);
        foreach (exp_q[i]) begin
            chk("stream_a", bus.a, exp_q[i][1]);
            chk("stream_av", bus.a_valid, exp_q[i][0]);
            chk("stream_busy", bus.busy, 1'b1);
            chk("stream_done", bus.done, 1'b0);
            if (det && i == 2) chk("unlock", unlock, 1'b1);
            if (rnd) begin
                bus.start = 1'($urandom);
                bus.pattern = 3'($urandom);
                bus.reps = 4'($urandom);
                bus.gap = 4'($urandom);
            end
            step();
        end
        bus.start = 1'b0;
        chk("done_pulse", bus.done, 1'b1);
        chk("done_busy", bus.busy, 1'b1);
        chk("done_a", bus.a, 1'b1);
        chk("done_av", bus.a_valid, 1'b0);
        step();
        chk_idle("after_done");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pattern = '0;
        bus.reps = '0;
        bus.gap = '0;
        #12;
        chk_idle("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk_idle("post_reset");

        run_tx(3'b001, 1, 0, 1'b0, 1'b1);
        run_tx(3'b101, 3, 2, 1'b0, 1'b0);
        run_tx(3'b011, 0, 5, 1'b0, 1'b0);
        run_tx(3'b110, 2, 0, 1'b1, 1'b0);

        // abort on the second bit
        bus.start = 1'b1;
        bus.pattern = 3'b010;
        bus.reps = 4'd2;
        bus.gap = 4'd1;
        step();
        bus.start = 1'b0;
        chk("abort_bit0", bus.a, 1'b0);
        step();
        chk("abort_bit1", bus.a, 1'b1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk_idle("abort");
        repeat (6) begin
            step();
            chk("abort_no_done", bus.done, 1'b0);
        end
        run_tx(3'b100, 1, 3, 1'b0, 1'b0);

        // start together with abort in IDLE is dropped
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        chk_idle("start_abort");
        bus.start = 1'b0;
        step();
        chk_idle("start_abort2");
        bus.abort = 1'b0;

        for (int t = 0; t < 10; t++)
            run_tx(3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, 1'b0);

        // asynchronous reset in the middle of a gap
        bus.start = 1'b1;
        bus.pattern = 3'b101;
        bus.reps = 4'd2;
        bus.gap = 4'd3;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        chk("gap_av", bus.a_valid, 1'b0);
        chk("gap_busy", bus.busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle("async_reset");
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        step();
        chk_idle("after_async");
        run_tx(3'b001, 1, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
